// File: rtl/ultra_defs_pkg.sv
// ---------------------------------------------------------------------------
// ultra_defs_pkg
// Shared definitions for the ultrasonic ranger: FSM state encoding, default
// timing constants (50 MHz clock) and the saturation / timeout distance code.
// The bus peripheral above the core imports the same package so both sides
// agree on the FFFF code and the timing defaults.
// ---------------------------------------------------------------------------
package ultra_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_RESULT    = 3'd4,
    ST_HOLDOFF   = 3'd5
  } ultra_state_t;

  localparam int DEF_TRIG_CYCLES    = 500;        // 10 us
  localparam int DEF_TICKS_PER_CM   = 2900;       // 58 us per cm
  localparam int DEF_RISE_TIMEOUT   = 1_500_000;  // 30 ms
  localparam int DEF_ECHO_TIMEOUT   = 1_500_000;  // 30 ms
  localparam int DEF_HOLDOFF_CYCLES = 3_000_000;  // 60 ms
  localparam int DEF_FILT_CYCLES    = 8;

  // Distance reported on timeout, also the cm counter saturation value.
  localparam logic [15:0] DIST_SAT = 16'hFFFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ultra_echo_cond.sv
// ---------------------------------------------------------------------------
// ultra_echo_cond
// Brings the raw, asynchronous sensor echo into the clk domain.
//   - SYNC_STAGES-deep synchroniser (default 2). Both edges see the same
//     delay, so pulse width is preserved.
//   - Optional glitch filter, enabled by defining ULTRA_ECHO_FILTER_EN: the
//     output only follows the synchronised echo after FILT_CYCLES consecutive
//     samples that differ from the current output. Latency is FILT_CYCLES on
//     both edges, so width is still preserved; shorter glitches vanish.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-low reset
//   echo    in   raw echo from the sensor
//   echo_s  out  conditioned echo, clk domain
// ---------------------------------------------------------------------------
module ultra_echo_cond
  import ultra_defs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef ULTRA_ECHO_FILTER_EN
  , parameter int FILT_CYCLES = DEF_FILT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], echo};
    end
  end

`ifdef ULTRA_ECHO_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

  logic          filt_reg;
  logic [FW-1:0] fcnt_reg;

  // Count consecutive samples that disagree with the current output; any
  // agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_reg <= 1'b0;
      fcnt_reg <= '0;
    end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
      fcnt_reg <= '0;
    end else if (fcnt_reg == FILT_LAST) begin
      filt_reg <= sync_reg[SYNC_STAGES-1];
      fcnt_reg <= '0;
    end else begin
      fcnt_reg <= fcnt_reg + FW'(1);
    end
  end

  assign echo_s = filt_reg;
`else
  assign echo_s = sync_reg[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/ultra_ranger_core.sv
// ---------------------------------------------------------------------------
// ultra_ranger_core
// Timing engine for an HC-SR04-style ultrasonic ranger: issues the trigger
// pulse, measures the echo high time and converts it to whole centimetres.
// Optional echo glitch filter: define ULTRA_ECHO_FILTER_EN.
// Ports:
//   clk       in   system clock (50 MHz nominal)
//   rst       in   asynchronous active-low reset
//   start     in   1-cycle request, accepted only while busy=0
//   echo      in   raw sensor echo (asynchronous)
//   trigg     out  sensor trigger pulse
//   busy      out  high from start acceptance until holdoff ends
//   ready     out  result valid, cleared on start acceptance
//   timeout   out  last result aborted (no echo / echo too long)
//   distance  out  last result in cm, FFFF on timeout or overflow
// ---------------------------------------------------------------------------
module ultra_ranger_core
  import ultra_defs_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TICKS_PER_CM   = DEF_TICKS_PER_CM,
  parameter int RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
  parameter int ECHO_TIMEOUT   = DEF_ECHO_TIMEOUT,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int FILT_CYCLES    = DEF_FILT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        echo,
  output logic        trigg,
  output logic        busy,
  output logic        ready,
  output logic        timeout,
  output logic [15:0] distance
);

  localparam int CNT_MAX = max2(max2(max2(TRIG_CYCLES, TICKS_PER_CM),
                                     max2(RISE_TIMEOUT, ECHO_TIMEOUT)),
                                max2(HOLDOFF_CYCLES, FILT_CYCLES));
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] SUB_LAST  = CNT_W'(TICKS_PER_CM - 1);
  // The rising-edge cycle is itself the first high cycle of the pulse, so the
  // cm counters are preloaded with one tick already applied.
  localparam logic [CNT_W-1:0] FIRST_SUB = (TICKS_PER_CM == 1) ? '0 : CNT_ONE;
  localparam logic [15:0]      FIRST_CM  = (TICKS_PER_CM == 1) ? 16'd1 : 16'd0;

  ultra_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;        // per-state timer / echo-high count
  logic [CNT_W-1:0] sub_reg;        // ticks within the current cm
  logic [15:0]      cm_reg;
  logic             res_to_reg;     // outcome carried into RESULT
  logic             echo_prev_reg;
  logic             ready_reg, timeout_reg;
  logic [15:0]      distance_reg;

  logic echo_s, echo_rise, trig_done, rise_expired, echo_expired, hold_done;

  ultra_echo_cond #(
    .SYNC_STAGES (2)
`ifdef ULTRA_ECHO_FILTER_EN
    , .FILT_CYCLES (FILT_CYCLES)
`endif
  ) u_echo_cond (
    .clk    (clk),
    .rst    (rst),
    .echo   (echo),
    .echo_s (echo_s)
  );

  // An echo already high when WAIT_RISE is entered has echo_prev_reg=1 and
  // therefore never produces a rise.
  assign echo_rise    = echo_s & ~echo_prev_reg;
  assign trig_done    = (cnt_reg == TRIG_LAST);
  assign rise_expired = (cnt_reg == RISE_LAST);
  assign echo_expired = (cnt_reg == ECHO_MAX);
  assign hold_done    = (cnt_reg == HOLD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start) state_next = ST_TRIG;
      ST_TRIG:      if (trig_done) state_next = ST_WAIT_RISE;
      ST_WAIT_RISE: if (echo_rise) state_next = ST_MEASURE;
                    else if (rise_expired) state_next = ST_RESULT;
      // Expiry is tested first so it wins over a simultaneous echo fall.
      ST_MEASURE:   if (echo_expired || !echo_s) state_next = ST_RESULT;
      ST_RESULT:    state_next = ST_HOLDOFF;
      ST_HOLDOFF:   if (hold_done) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    trigg = (state_reg == ST_TRIG);
    busy  = (state_reg != ST_IDLE);
  end

  assign ready    = ready_reg;
  assign timeout  = timeout_reg;
  assign distance = distance_reg;

  // Counters and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      sub_reg       <= '0;
      cm_reg        <= '0;
      res_to_reg    <= 1'b0;
      echo_prev_reg <= 1'b0;
      ready_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      distance_reg  <= '0;
    end else begin
      echo_prev_reg <= echo_s;

      // Timer restarts on every state change; MEASURE starts at 1 because
      // the rise cycle already counts as echo-high time.
      if (state_next != state_reg)
        cnt_reg <= (state_next == ST_MEASURE) ? CNT_ONE : '0;
      else if (state_reg != ST_IDLE)
        cnt_reg <= cnt_reg + CNT_ONE;

      if (state_reg == ST_WAIT_RISE && echo_rise) begin
        sub_reg <= FIRST_SUB;
        cm_reg  <= FIRST_CM;
      end else if (state_reg == ST_MEASURE && echo_s && !echo_expired) begin
        if (sub_reg == SUB_LAST) begin
          sub_reg <= '0;
          if (cm_reg != DIST_SAT) cm_reg <= cm_reg + 16'd1;
        end else begin
          sub_reg <= sub_reg + CNT_ONE;
        end
      end

      // Only the value present when the state is left matters.
      if (state_reg == ST_WAIT_RISE)    res_to_reg <= ~echo_rise;
      else if (state_reg == ST_MEASURE) res_to_reg <= echo_expired;

      if (state_reg == ST_IDLE && start) begin
        ready_reg   <= 1'b0;
        timeout_reg <= 1'b0;
      end else if (state_reg == ST_RESULT) begin
        ready_reg    <= 1'b1;
        timeout_reg  <= res_to_reg;
        distance_reg <= res_to_reg ? DIST_SAT : cm_reg;
      end
    end
  end

endmodule
